// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types, frame geometry and parity-mode constants.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DPS   = 2'd1,
    ST_CHECK = 2'd2
  } ps2_state_e;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned BITCNT_W   = 4;

  localparam int unsigned PARITY_IGNORE = 0;
  localparam int unsigned PARITY_ODD    = 1;

  // Odd parity holds when data bits plus parity bit XOR to 1.
  function automatic logic parity_ok(input logic [8:0] data_par, input int unsigned mode);
    if (mode == PARITY_IGNORE) begin
      return 1'b1;
    end
    return ^data_par;
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Push/pop bus between the PS/2 frame receiver and its receive FIFO.
interface ps2_rx_fifo_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;

  modport master (
    output push, pop, wdata,
    input  rdata, empty, full, count
  );

  modport slave (
    input  push, pop, wdata,
    output rdata, empty, full, count
  );

endinterface

// File: rtl/ps2_sync_fifo.sv
// First-word fall-through FIFO; a push into a full FIFO only lands when a pop frees a slot.
module ps2_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input logic           clk,
  input logic           reset,
  ps2_rx_fifo_if.slave  bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_c;
  logic             empty_c;
  logic             wr_fire_c;
  logic             rd_fire_c;

  always_comb begin
    full_c    = (count_q == CW'(DEPTH));
    empty_c   = (count_q == '0);
    rd_fire_c = bus.pop & ~empty_c;
    wr_fire_c = bus.push & (~full_c | rd_fire_c);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (wr_fire_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_fire_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({wr_fire_c, rd_fire_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (wr_fire_c) begin
      mem_q[wr_ptr_q] <= bus.wdata;
    end
  end

  assign bus.rdata = empty_c ? '0 : mem_q[rd_ptr_q];
  assign bus.empty = empty_c;
  assign bus.full  = full_c;
  assign bus.count = count_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronise and filter the lines, deframe 11-bit
// frames, check stop/parity and queue good bytes in a receive FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN   = 8,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned TIMEOUT_CYC  = 50000,
  parameter int unsigned CHECK_PARITY = PARITY_ODD
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ps2d,
  input  logic                        ps2c,
  input  logic                        rd_en,
  output logic [7:0]                  dout,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        rx_done_tick,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        overflow
);

  localparam int unsigned TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC - 1);

  logic [1:0]            ps2c_sync_q;
  logic [1:0]            ps2d_sync_q;
  logic                  ps2d_s;
  logic [FILTER_LEN-1:0] filter_q, filter_d;
  logic                  fclk_q, fclk_d;
  logic                  fall_edge;

  ps2_state_e            state_q, state_d;
  logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [TO_W-1:0]       tmo_q, tmo_d;

  logic push_c, done_c, perr_c, ferr_c, ovf_c;

  ps2_rx_fifo_if #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) fifo_bus ();

  // Two-flop synchronisers; idle-high lines reset to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps2c_sync_q <= 2'b11;
      ps2d_sync_q <= 2'b11;
    end else begin
      ps2c_sync_q <= {ps2c_sync_q[0], ps2c};
      ps2d_sync_q <= {ps2d_sync_q[0], ps2d};
    end
  end

  assign ps2d_s = ps2d_sync_q[1];

  // Glitch filter: the clock only changes after FILTER_LEN agreeing samples.
  always_comb begin
    filter_d = {ps2c_sync_q[1], filter_q[FILTER_LEN-1:1]};
    fclk_d   = fclk_q;
    if (&filter_d) begin
      fclk_d = 1'b1;
    end else if (~|filter_d) begin
      fclk_d = 1'b0;
    end
  end

  assign fall_edge = fclk_q & ~fclk_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      filter_q <= '1;
      fclk_q   <= 1'b1;
    end else begin
      filter_q <= filter_d;
      fclk_q   <= fclk_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      frame_q  <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      frame_q  <= frame_d;
      tmo_q    <= tmo_d;
    end
  end

  // Frame FSM; frame bits land LSB-first: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    frame_d  = frame_q;
    tmo_d    = tmo_q;
    push_c   = 1'b0;
    done_c   = 1'b0;
    perr_c   = 1'b0;
    ferr_c   = 1'b0;
    ovf_c    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        if (fall_edge && !ps2d_s) begin
          frame_d  = {ps2d_s, frame_q[FRAME_BITS-1:1]};
          bitcnt_d = BITCNT_W'(FRAME_BITS - 2);
          state_d  = ST_DPS;
        end
      end
      ST_DPS: begin
        if (fall_edge) begin
          tmo_d   = '0;
          frame_d = {ps2d_s, frame_q[FRAME_BITS-1:1]};
          if (bitcnt_q == '0) begin
            state_d = ST_CHECK;
          end else begin
            bitcnt_d = bitcnt_q - BITCNT_W'(1);
          end
        end else if (tmo_q == TO_MAX) begin
          ferr_c  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TO_W'(1);
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (!frame_q[FRAME_BITS-1] || frame_q[0]) begin
          ferr_c = 1'b1;
        end else if (!parity_ok(frame_q[9:1], CHECK_PARITY)) begin
          perr_c = 1'b1;
        end else if (fifo_bus.full && !rd_en) begin
          ovf_c = 1'b1;
        end else begin
          push_c = 1'b1;
          done_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign fifo_bus.push  = push_c;
  assign fifo_bus.pop   = rd_en;
  assign fifo_bus.wdata = frame_q[8:1];

  ps2_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .bus   (fifo_bus.slave)
  );

  // Status pulses coincide with the CHECK-cycle push decision, which depends on rd_en.
  assign dout         = fifo_bus.rdata;
  assign empty        = fifo_bus.empty;
  assign full         = fifo_bus.full;
  assign count        = fifo_bus.count;
  assign rx_done_tick = done_c;
  assign parity_err   = perr_c;
  assign frame_err    = ferr_c;
  assign overflow     = ovf_c;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: byte-level PS/2 frames in, FIFO pops checked against a queue.
module tb_ps2_rx_fifo;

  localparam int unsigned FILTER_LEN = 8;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned TMO        = 120;
  localparam int unsigned Q          = 10;
  localparam int unsigned H          = 20;
  localparam int unsigned LAT        = FILTER_LEN + 2;
  localparam int unsigned CW         = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset, ps2c, ps2d, rd_en, np_rd_en;

  logic [7:0]    dout;
  logic          empty, full, done, perr, ferr, ovf;
  logic [CW-1:0] count;

  logic [7:0] np_dout;
  logic       np_empty, np_full, np_done, np_perr, np_ferr, np_ovf;
  logic [3:0] np_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt = 0, perr_cnt = 0, ferr_cnt = 0, ovf_cnt = 0;
  int np_done_cnt = 0, np_err_cnt = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .FILTER_LEN(FILTER_LEN), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .CHECK_PARITY(1)
  ) dut (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rd_en(rd_en),
    .dout(dout), .empty(empty), .full(full), .count(count),
    .rx_done_tick(done), .parity_err(perr), .frame_err(ferr), .overflow(ovf)
  );

  ps2_rx_fifo #(
    .FILTER_LEN(FILTER_LEN), .FIFO_DEPTH(8), .TIMEOUT_CYC(TMO), .CHECK_PARITY(0)
  ) dut_np (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .rd_en(np_rd_en),
    .dout(np_dout), .empty(np_empty), .full(np_full), .count(np_count),
    .rx_done_tick(np_done), .parity_err(np_perr), .frame_err(np_ferr), .overflow(np_ovf)
  );

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (perr) perr_cnt <= perr_cnt + 1;
    if (ferr) ferr_cnt <= ferr_cnt + 1;
    if (ovf)  ovf_cnt  <= ovf_cnt + 1;
    if (np_done) np_done_cnt <= np_done_cnt + 1;
    if (np_perr || np_ferr || np_ovf) np_err_cnt <= np_err_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2d = b;
    wait_cyc(Q);
    ps2c = 1'b0;
    wait_cyc(H);
    ps2c = 1'b1;
    wait_cyc(Q);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic bad_par);
    logic [10:0] bits;
    bits = {1'b1, (~^data) ^ bad_par, data, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i]);
    wait_cyc(H);
  endtask

  task automatic pop_one(output logic [7:0] got);
    got   = dout;
    rd_en = 1'b1;
    wait_cyc(1);
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(2);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
    n_cmp++; if ({done, perr, ferr, ovf} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_pulses: got %b want 0000", {done, perr, ferr, ovf});
    end
  endtask

  task automatic test_basic();
    int d0, f0;
    logic [7:0] got, exp;
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h1C, 1'b0);
    exp_q.push_back(8'h1C);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL basic_done: got %0d want 1", done_cnt - d0); end
    n_cmp++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL basic_ferr: got %0d want 0", ferr_cnt - f0); end
    n_cmp++; if (count !== CW'(1)) begin n_fail++; $display("FAIL basic_count: got %0d want 1", count); end
    n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL basic_nonempty: got %b want 0", empty); end
    pop_one(got);
    exp = exp_q.pop_front();
    n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL basic_dout: got %h want %h", got, exp); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty_after_rd: got %b want 1", empty); end
  endtask

  task automatic test_parity();
    int p0, d0, nd0, ne0;
    do_reset();
    exp_q.delete();
    p0 = perr_cnt; d0 = done_cnt; nd0 = np_done_cnt; ne0 = np_err_cnt;
    send_frame(8'h1C, 1'b1);
    n_cmp++; if (perr_cnt - p0 !== 1) begin n_fail++; $display("FAIL parity_err: got %0d want 1", perr_cnt - p0); end
    n_cmp++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL parity_nopush_done: got %0d want 0", done_cnt - d0); end
    n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL parity_count: got %0d want 0", count); end
    n_cmp++; if (np_count !== 4'd1) begin n_fail++; $display("FAIL noparity_count: got %0d want 1", np_count); end
    n_cmp++; if (np_dout !== 8'h1C) begin n_fail++; $display("FAIL noparity_dout: got %h want 1c", np_dout); end
    n_cmp++; if (np_done_cnt - nd0 !== 1) begin n_fail++; $display("FAIL noparity_done: got %0d want 1", np_done_cnt - nd0); end
    n_cmp++; if (np_err_cnt - ne0 !== 0 || np_empty !== 1'b0 || np_full !== 1'b0) begin
      n_fail++; $display("FAIL noparity_status: errs %0d empty %b full %b want 0 0 0", np_err_cnt - ne0, np_empty, np_full);
    end
  endtask

  task automatic test_timeout();
    int f0, d0;
    logic [7:0] got, exp;
    f0 = ferr_cnt;
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    wait_cyc(TMO + 40);
    n_cmp++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL timeout_ferr: got %0d want 1", ferr_cnt - f0); end
    n_cmp++; if (count !== '0) begin n_fail++; $display("FAIL timeout_count: got %0d want 0", count); end
    d0 = done_cnt;
    send_frame(8'hF0, 1'b0);
    exp_q.push_back(8'hF0);
    n_cmp++; if (done_cnt - d0 !== 1 || ferr_cnt - f0 !== 1) begin
      n_fail++; $display("FAIL timeout_recover: done %0d ferr %0d want 1 1", done_cnt - d0, ferr_cnt - f0);
    end
    pop_one(got);
    exp = exp_q.pop_front();
    n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL timeout_dout: got %h want %h", got, exp); end
  endtask

  task automatic test_overflow();
    int o0, d0;
    logic [7:0] got, exp;
    logic [10:0] bits;
    o0 = ovf_cnt; d0 = done_cnt;
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1'b0);
      exp_q.push_back(8'(i));
    end
    n_cmp++; if (full !== 1'b1 || count !== CW'(4)) begin n_fail++; $display("FAIL ovf_full: full %b count %0d want 1 4", full, count); end
    send_frame(8'h05, 1'b0);
    n_cmp++; if (ovf_cnt - o0 !== 1) begin n_fail++; $display("FAIL ovf_pulse: got %0d want 1", ovf_cnt - o0); end
    n_cmp++; if (done_cnt - d0 !== 4) begin n_fail++; $display("FAIL ovf_done: got %0d want 4", done_cnt - d0); end
    for (int i = 0; i < 4; i++) begin
      pop_one(got);
      exp = exp_q.pop_front();
      n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL ovf_read%0d: got %h want %h", i, got, exp); end
    end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drained: got %b want 1", empty); end

    // Refill, then pop in the exact CHECK cycle of the next frame.
    for (int i = 6; i <= 9; i++) begin
      send_frame(8'(i), 1'b0);
      exp_q.push_back(8'(i));
    end
    o0 = ovf_cnt; d0 = done_cnt;
    bits = {1'b1, ~^8'h0A, 8'h0A, 1'b0};
    for (int i = 0; i < 10; i++) send_bit(bits[i]);
    ps2d = 1'b1;
    wait_cyc(Q);
    ps2c = 1'b0;
    wait_cyc(LAT);
    got   = dout;
    rd_en = 1'b1;
    #1;
    n_cmp++; if (done !== 1'b1 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL coincide_pulse: done %b overflow %b want 1 0", done, ovf);
    end
    wait_cyc(1);
    rd_en = 1'b0;
    wait_cyc(H - LAT - 1);
    ps2c = 1'b1;
    wait_cyc(Q + H);
    exp = exp_q.pop_front();
    exp_q.push_back(8'h0A);
    n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL coincide_head: got %h want %h", got, exp); end
    n_cmp++; if (count !== CW'(4)) begin n_fail++; $display("FAIL coincide_count: got %0d want 4", count); end
    n_cmp++; if (ovf_cnt - o0 !== 0 || done_cnt - d0 !== 1) begin
      n_fail++; $display("FAIL coincide_counts: ovf %0d done %0d want 0 1", ovf_cnt - o0, done_cnt - d0);
    end
    for (int i = 0; i < 4; i++) begin
      pop_one(got);
      exp = exp_q.pop_front();
      n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL coincide_read%0d: got %h want %h", i, got, exp); end
    end
  endtask

  task automatic test_glitch_reset();
    int tot0, d0;
    logic [7:0] got, exp;
    tot0 = done_cnt + perr_cnt + ferr_cnt + ovf_cnt;
    ps2d = 1'b0;
    wait_cyc(Q);
    ps2c = 1'b0;
    wait_cyc(FILTER_LEN - 1);
    ps2c = 1'b1;
    wait_cyc(H);
    ps2d = 1'b1;
    wait_cyc(H);
    n_cmp++; if (done_cnt + perr_cnt + ferr_cnt + ovf_cnt !== tot0) begin
      n_fail++; $display("FAIL glitch_pulses: got %0d want %0d", done_cnt + perr_cnt + ferr_cnt + ovf_cnt, tot0);
    end
    d0 = done_cnt;
    send_frame(8'h3C, 1'b0);
    exp_q.push_back(8'h3C);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL glitch_frame_done: got %0d want 1", done_cnt - d0); end
    pop_one(got);
    exp = exp_q.pop_front();
    n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL glitch_frame_dout: got %h want %h", got, exp); end

    tot0 = done_cnt + perr_cnt + ferr_cnt + ovf_cnt;
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    do_reset();
    wait_cyc(TMO + 20);
    n_cmp++; if (count !== '0 || empty !== 1'b1 || dout !== 8'h00) begin
      n_fail++; $display("FAIL midreset_state: count %0d empty %b dout %h want 0 1 00", count, empty, dout);
    end
    n_cmp++; if (done_cnt + perr_cnt + ferr_cnt + ovf_cnt !== tot0) begin
      n_fail++; $display("FAIL midreset_pulses: got %0d want %0d", done_cnt + perr_cnt + ferr_cnt + ovf_cnt, tot0);
    end
    d0 = done_cnt;
    send_frame(8'h5A, 1'b0);
    exp_q.push_back(8'h5A);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL midreset_next_done: got %0d want 1", done_cnt - d0); end
    pop_one(got);
    exp = exp_q.pop_front();
    n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL midreset_next_dout: got %h want %h", got, exp); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL midreset_final_empty: got %b want 1", empty); end
  endtask

  initial begin
    reset    = 1'b1;
    ps2c     = 1'b1;
    ps2d     = 1'b1;
    rd_en    = 1'b0;
    np_rd_en = 1'b0;
    wait_cyc(3);
    test_reset();
    test_basic();
    test_parity();
    test_timeout();
    test_overflow();
    test_glitch_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
